// File: rtl/pwm_preconditioner_pkg.sv
// Shared types and constants for the PWM rise/fall preconditioner.
package pwm_preconditioner_pkg;

    localparam int unsigned DEFAULT_WIDTH     = 13;
    localparam int unsigned DEFAULT_TRANS_NUM = 249;

    // Register stages in the rise/fall calculation pipeline
    localparam int unsigned PIPE_DEPTH = 3;

    // Width of a counter that spans 0..n-1 (never narrower than one bit)
    function automatic int unsigned count_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StCommit
    } state_e;

endpackage

// File: rtl/pwm_preconditioner_calc.sv
// Three-stage rise/fall arithmetic: clamp/halve, sum, reduce (mod T by conditional subtract).
module pwm_preconditioner_calc
    import pwm_preconditioner_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [WIDTH-1:0] in_cycle,
    input  logic [WIDTH-1:0] in_duty,
    input  logic [WIDTH-1:0] in_phase,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [WIDTH-1:0] out_rise,
    output logic [WIDTH-1:0] out_fall
);

    // One extra bit so 2T and T + ceil(Dc/2) never overflow
    localparam int unsigned EW = WIDTH + 1;
    typedef logic [EW-1:0] ext_t;

    ext_t c1_t, c1_dc, c1_pc, c1_dfloor, c1_dceil;

    logic             s1_valid;
    logic [IDX_W-1:0] s1_idx;
    ext_t             s1_t, s1_pc, s1_dfloor, s1_dceil;

    ext_t c2_r_sum, c2_f_sum;

    logic             s2_valid;
    logic [IDX_W-1:0] s2_idx;
    ext_t             s2_t, s2_r_sum, s2_f_sum;

    ext_t             c3_two_t;
    logic [WIDTH-1:0] c3_rise, c3_fall;

    logic             s3_valid;
    logic [IDX_W-1:0] s3_idx;
    logic [WIDTH-1:0] s3_rise, s3_fall;

    // Stage 1 logic: clamp duty and phase to the period, split duty into floor/ceil halves
    always_comb begin
        c1_t      = ext_t'(in_cycle);
        c1_dc     = (in_duty > in_cycle) ? ext_t'(in_cycle) : ext_t'(in_duty);
        c1_pc     = (in_phase > in_cycle) ? ext_t'(in_cycle) : ext_t'(in_phase);
        c1_dfloor = c1_dc >> 1;
        c1_dceil  = (c1_dc + ext_t'(1)) >> 1;
    end

    // Stage 1 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_idx    <= '0;
            s1_t      <= '0;
            s1_pc     <= '0;
            s1_dfloor <= '0;
            s1_dceil  <= '0;
        end else begin
            s1_valid  <= in_valid;
            s1_idx    <= in_idx;
            s1_t      <= c1_t;
            s1_pc     <= c1_pc;
            s1_dfloor <= c1_dfloor;
            s1_dceil  <= c1_dceil;
        end
    end

    // Stage 2 logic: unreduced sums; both stay within [0, 2T] given the clamps
    always_comb begin
        c2_r_sum = (s1_t << 1) - s1_pc - s1_dfloor;
        c2_f_sum = s1_t - s1_pc + s1_dceil;
    end

    // Stage 2 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_idx   <= '0;
            s2_t     <= '0;
            s2_r_sum <= '0;
            s2_f_sum <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_idx   <= s1_idx;
            s2_t     <= s1_t;
            s2_r_sum <= c2_r_sum;
            s2_f_sum <= c2_f_sum;
        end
    end

    // Stage 3 logic: fold the sums back into [0, T); T = 0 falls through to zero
    always_comb begin
        c3_two_t = s2_t << 1;
        if (s2_r_sum >= c3_two_t) begin
            c3_rise = WIDTH'(s2_r_sum - c3_two_t);
        end else if (s2_r_sum >= s2_t) begin
            c3_rise = WIDTH'(s2_r_sum - s2_t);
        end else begin
            c3_rise = WIDTH'(s2_r_sum);
        end
        if (s2_f_sum >= s2_t) begin
            c3_fall = WIDTH'(s2_f_sum - s2_t);
        end else begin
            c3_fall = WIDTH'(s2_f_sum);
        end
    end

    // Stage 3 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_idx   <= '0;
            s3_rise  <= '0;
            s3_fall  <= '0;
        end else begin
            s3_valid <= s2_valid;
            s3_idx   <= s2_idx;
            s3_rise  <= c3_rise;
            s3_fall  <= c3_fall;
        end
    end

    assign out_valid = s3_valid;
    assign out_idx   = s3_idx;
    assign out_rise  = s3_rise;
    assign out_fall  = s3_fall;

endmodule

// File: rtl/pwm_preconditioner.sv
// Free-running round sequencer: issues every transducer through the calc pipeline,
// collects results in a shadow buffer and commits them to RISE/FALL in one cycle.
module pwm_preconditioner
    import pwm_preconditioner_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned TRANS_NUM = DEFAULT_TRANS_NUM
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] CYCLE [TRANS_NUM],
    input  logic [WIDTH-1:0] DUTY  [TRANS_NUM],
    input  logic [WIDTH-1:0] PHASE [TRANS_NUM],
    output logic [WIDTH-1:0] RISE  [TRANS_NUM],
    output logic [WIDTH-1:0] FALL  [TRANS_NUM],
    output logic             DONE
);

    localparam int unsigned IDX_W   = count_width(TRANS_NUM);
    localparam int unsigned DRAIN_W = count_width(PIPE_DEPTH);

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(TRANS_NUM - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(PIPE_DEPTH - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;

    logic issue;
    logic commit_load;

    logic [WIDTH-1:0] mux_cycle, mux_duty, mux_phase;

    logic             calc_valid;
    logic [IDX_W-1:0] calc_idx;
    logic [WIDTH-1:0] calc_rise, calc_fall;

    logic [WIDTH-1:0] shadow_rise_q [TRANS_NUM];
    logic [WIDTH-1:0] shadow_fall_q [TRANS_NUM];
    logic [WIDTH-1:0] shadow_rise_d [TRANS_NUM];
    logic [WIDTH-1:0] shadow_fall_d [TRANS_NUM];

    logic [WIDTH-1:0] rise_q [TRANS_NUM];
    logic [WIDTH-1:0] fall_q [TRANS_NUM];

    // State register with issue index and drain counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            idx_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic: IDLE once, then RUN -> DRAIN -> COMMIT forever
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                state_d = StRun;
                idx_d   = '0;
            end
            StRun: begin
                if (idx_q == LAST_IDX) begin
                    state_d = StDrain;
                    idx_d   = '0;
                    drain_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = StCommit;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StCommit: begin
                state_d = StRun;
                idx_d   = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from state; the commit load fires on the edge entering COMMIT
    // so RISE/FALL change in the same cycle DONE is high
    always_comb begin
        issue       = (state_q == StRun);
        commit_load = (state_q == StDrain) && (state_d == StCommit);
        DONE        = (state_q == StCommit);
    end

    // Input multiplexer: the issued index's triple is presented to the pipeline
    always_comb begin
        mux_cycle = CYCLE[idx_q];
        mux_duty  = DUTY[idx_q];
        mux_phase = PHASE[idx_q];
    end

    pwm_preconditioner_calc #(
        .WIDTH(WIDTH),
        .IDX_W(IDX_W)
    ) u_calc (
        .clk      (CLK),
        .rst      (RST),
        .in_valid (issue),
        .in_idx   (idx_q),
        .in_cycle (mux_cycle),
        .in_duty  (mux_duty),
        .in_phase (mux_phase),
        .out_valid(calc_valid),
        .out_idx  (calc_idx),
        .out_rise (calc_rise),
        .out_fall (calc_fall)
    );

    // Shadow next value includes the result landing this cycle, so the final index
    // (which retires on the commit edge) is not lost
    always_comb begin
        shadow_rise_d = shadow_rise_q;
        shadow_fall_d = shadow_fall_q;
        if (calc_valid) begin
            shadow_rise_d[calc_idx] = calc_rise;
            shadow_fall_d[calc_idx] = calc_fall;
        end
    end

    // Shadow buffer and committed outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow_rise_q <= '{default: '0};
            shadow_fall_q <= '{default: '0};
            rise_q        <= '{default: '0};
            fall_q        <= '{default: '0};
        end else begin
            shadow_rise_q <= shadow_rise_d;
            shadow_fall_q <= shadow_fall_d;
            if (commit_load) begin
                rise_q <= shadow_rise_d;
                fall_q <= shadow_fall_d;
            end
        end
    end

    assign RISE = rise_q;
    assign FALL = fall_q;

endmodule

// File: tb/tb_pwm_preconditioner.sv
// Randomised self-checking bench for pwm_preconditioner against a round-timing model.
module tb_pwm_preconditioner;

    localparam int W  = 13;
    localparam int TN = 249;
    localparam int RP = TN + 4;
    localparam int ND = 9;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] cyc_in   [TN];
    logic [W-1:0] duty_in  [TN];
    logic [W-1:0] phase_in [TN];
    logic [W-1:0] rise_o   [TN];
    logic [W-1:0] fall_o   [TN];
    logic         done_o;

    int tests = 0;
    int fails = 0;
    int nedge = 0;

    int snap_r [TN];
    int snap_f [TN];
    int exp_r  [TN];
    int exp_f  [TN];
    bit exp_done;

    // Directed cases: T, D, P and hand-computed R, F
    int dir_t [ND] = '{4096, 4096, 4096, 4096, 4096, 2000, 0, 3000, 3000};
    int dir_d [ND] = '{1000, 4096, 0,    4095, 1,    2500, 5, 1000, 1000};
    int dir_p [ND] = '{2048, 2048, 0,    1,    0,    2000, 7, 3000, 0};
    int dir_r [ND] = '{1548, 0,    0,    2048, 0,    1000, 0, 2500, 2500};
    int dir_f [ND] = '{2548, 0,    0,    2047, 1,    1000, 0, 500,  500};

    pwm_preconditioner #(
        .WIDTH    (W),
        .TRANS_NUM(TN)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .CYCLE(cyc_in),
        .DUTY (duty_in),
        .PHASE(phase_in),
        .RISE (rise_o),
        .FALL (fall_o),
        .DONE (done_o)
    );

    always #5 CLK = ~CLK;

    function automatic int model_rise(input int t, input int d, input int p);
        int dc, pc;
        if (t == 0) return 0;
        dc = (d < t) ? d : t;
        pc = (p < t) ? p : t;
        return (2 * t - pc - dc / 2) % t;
    endfunction

    function automatic int model_fall(input int t, input int d, input int p);
        int dc, pc;
        if (t == 0) return 0;
        dc = (d < t) ? d : t;
        pc = (p < t) ? p : t;
        return (t - pc + (dc + 1) / 2) % t;
    endfunction

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic randomize_one(input int i);
        int t;
        t = int'($urandom_range(8000, 2000));
        cyc_in[i]   = W'(t);
        duty_in[i]  = W'($urandom_range(t, 0));
        phase_in[i] = W'($urandom_range(t, 0));
    endtask

    task automatic randomize_all();
        for (int i = 0; i < TN; i++) randomize_one(i);
    endtask

    // Rising edges since reset release
    always @(posedge CLK) begin
        if (RST) nedge <= 0;
        else     nedge <= nedge + 1;
    end

    // Model + per-cycle compare: after release, round position p = (nedge-1) mod RP;
    // p < TN issues index p, p == RP-1 is the commit cycle
    always @(negedge CLK) begin
        int p;
        int bad;
        if (RST) begin
            exp_done = 1'b0;
            for (int i = 0; i < TN; i++) begin
                exp_r[i] = 0;
                exp_f[i] = 0;
            end
        end else begin
            exp_done = 1'b0;
            if (nedge >= 1) begin
                p = (nedge - 1) % RP;
                if (p < TN) begin
                    snap_r[p] = model_rise(int'(cyc_in[p]), int'(duty_in[p]), int'(phase_in[p]));
                    snap_f[p] = model_fall(int'(cyc_in[p]), int'(duty_in[p]), int'(phase_in[p]));
                end
                if (p == RP - 1) begin
                    exp_done = 1'b1;
                    exp_r    = snap_r;
                    exp_f    = snap_f;
                end
            end
        end
        tests++;
        if (done_o !== exp_done) begin
            fails++;
            $display("FAIL done_pulse: nedge=%0d got %b expected %b", nedge, done_o, exp_done);
        end
        bad = -1;
        for (int i = 0; i < TN; i++) begin
            if (bad < 0 && (rise_o[i] !== W'(exp_r[i]) || fall_o[i] !== W'(exp_f[i]))) bad = i;
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL rise_fall: nedge=%0d idx=%0d rise got %0d exp %0d, fall got %0d exp %0d",
                     nedge, bad, rise_o[bad], exp_r[bad], fall_o[bad], exp_f[bad]);
        end
    end

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int k = 0; k < 2 * RP + 8; k++) begin
            @(negedge CLK);
            if (done_o === 1'b1) begin
                got = 1'b1;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL done_timeout: no DONE within %0d cycles", 2 * RP + 8);
    endtask

    task automatic wait_pos(input int pos);
        for (int k = 0; k < 2 * RP + 8; k++) begin
            @(posedge CLK);
            #1;
            if (nedge >= 1 && (nedge - 1) % RP == pos) return;
        end
        tests++;
        fails++;
        $display("FAIL pos_timeout: index %0d never issued", pos);
    endtask

    initial begin
        bit got;
        int last_edge;
        int nz;
        int old_t, old_d, old_p, new_t, new_d, new_p;

        randomize_all();
        for (int j = 0; j < ND; j++) begin
            cyc_in[j]   = W'(dir_t[j]);
            duty_in[j]  = W'(dir_d[j]);
            phase_in[j] = W'(dir_p[j]);
        end

        // Reset state
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        nz = 0;
        for (int i = 0; i < TN; i++) if (rise_o[i] != 0 || fall_o[i] != 0) nz++;
        check("reset_outputs_nonzero", nz, 0);
        check("reset_done", int'(done_o), 0);
        #1 RST = 1'b0;

        // First DONE lands in cycle 1 (IDLE) + one full round after release
        wait_done(got);
        if (got) check("first_done_cycle", nedge + 1, 1 + RP);
        for (int j = 0; j < ND; j++) begin
            check($sformatf("directed_rise[%0d]", j), int'(rise_o[j]), dir_r[j]);
            check($sformatf("directed_fall[%0d]", j), int'(fall_o[j]), dir_f[j]);
        end
        last_edge = nedge;

        for (int r = 0; r < 100; r++) begin
            randomize_all();
            if (r == 50) begin
                old_t = int'(cyc_in[10]);
                old_d = int'(duty_in[10]);
                old_p = int'(phase_in[10]);
                wait_pos(50);
                // Index 10 already issued: change must wait a round; index 200 not yet
                new_t = int'($urandom_range(8000, 2000));
                new_d = int'($urandom_range(new_t, 0));
                new_p = int'($urandom_range(new_t, 0));
                cyc_in[10]   = W'(new_t);
                duty_in[10]  = W'(new_d);
                phase_in[10] = W'(new_p);
                cyc_in[200]   = W'(new_t);
                duty_in[200]  = W'(new_d);
                phase_in[200] = W'(new_p);
            end
            wait_done(got);
            if (!got) break;
            check("done_period", nedge - last_edge, RP);
            last_edge = nedge;
            if (r == 50) begin
                check("late_change_rise", int'(rise_o[10]), model_rise(old_t, old_d, old_p));
                check("late_change_fall", int'(fall_o[10]), model_fall(old_t, old_d, old_p));
                check("early_change_rise", int'(rise_o[200]), model_rise(new_t, new_d, new_p));
                check("early_change_fall", int'(fall_o[200]), model_fall(new_t, new_d, new_p));
            end
        end

        // Mid-round reset while index 100 is issued
        wait_pos(100);
        RST = 1'b1;
        #1;
        nz = 0;
        for (int i = 0; i < TN; i++) if (rise_o[i] != 0 || fall_o[i] != 0) nz++;
        check("midreset_outputs_nonzero", nz, 0);
        check("midreset_done", int'(done_o), 0);
        repeat (3) @(negedge CLK);
        #1 RST = 1'b0;
        wait_done(got);
        if (got) check("restart_done_cycle", nedge + 1, 1 + RP);
        last_edge = nedge;
        randomize_all();
        wait_done(got);
        if (got) check("restart_done_period", nedge - last_edge, RP);
        @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
